// File: rtl/id_ex_stage_reg_pkg.sv
// id_ex_stage_reg_pkg: shared MIPS32 definitions for the ID/EX stage.
// Holds the ALU opcodes, the zero register index and the bubble control vector.
package id_ex_stage_reg_pkg;
  localparam int ALUOP_W = 4;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                                 ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7,
                                 ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_LUI = 4'd10;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// load_use_detect: combinational compare of a load in EX against the sources read in ID.
module load_use_detect
  import id_ex_stage_reg_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_dst_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  output logic             hazard_o
);
  assign hazard_o = ex_valid_i && ex_mem_read_i && ex_dst_i != REG_W'(REG_ZERO) && id_valid_i &&
                    (ex_dst_i == id_rs_i || (id_uses_rt_i && ex_dst_i == id_rt_i));
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use bubble, flush, hold and WB bypass.
// Define ID_EX_STALL_STATS_EN to add saturating load-use and flush counters.
module id_ex_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_ID,
  input  logic [REG_W-1:0]   rs_ID,
  input  logic [REG_W-1:0]   rt_ID,
  input  logic [REG_W-1:0]   dst_ID,
  input  logic               uses_rt_ID,
  input  logic [DATA_W-1:0]  rs_data_ID,
  input  logic [DATA_W-1:0]  rt_data_ID,
  input  logic [DATA_W-1:0]  imm_ID,
  input  logic               RegWrite_ID,
  input  logic               MemRead_ID,
  input  logic               MemWrite_ID,
  input  logic               MemtoReg_ID,
  input  logic               ALUSrc_ID,
  input  logic [ALUOP_W-1:0] ALUOp_ID,
  input  logic               RegWrite_WB,
  input  logic [REG_W-1:0]   rd_WB,
  input  logic [DATA_W-1:0]  wdata_WB,
  input  logic               flush_EX,
  input  logic               hold_EX,
  output logic               valid_EX,
  output logic [REG_W-1:0]   rs_EX,
  output logic [REG_W-1:0]   rt_EX,
  output logic [REG_W-1:0]   dst_EX,
  output logic [DATA_W-1:0]  rs_data_EX,
  output logic [DATA_W-1:0]  rt_data_EX,
  output logic [DATA_W-1:0]  imm_EX,
  output logic               RegWrite_EX,
  output logic               MemRead_EX,
  output logic               MemWrite_EX,
  output logic               MemtoReg_EX,
  output logic               ALUSrc_EX,
  output logic [ALUOP_W-1:0] ALUOp_EX,
  output logic               stall_ID
`ifdef ID_EX_STALL_STATS_EN
  ,
  output logic [31:0]        load_use_cnt,
  output logic [31:0]        flush_cnt
`endif
);
  import id_ex_stage_reg_pkg::*;
  typedef struct packed {
    logic               valid;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   dst;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic [DATA_W-1:0]  imm;
    ctrl_t              ctrl;
    logic [ALUOP_W-1:0] alu_op;
  } ex_t;
  localparam ex_t BUBBLE = '{ctrl: CTRL_BUBBLE, default: '0};
  ex_t  ex_q, ex_d, cap;
  logic load_use, rs_byp, rt_byp;
  load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .ex_valid_i   (ex_q.valid),
    .ex_mem_read_i(ex_q.ctrl.mem_read),
    .ex_dst_i     (ex_q.dst),
    .id_valid_i   (valid_ID),
    .id_rs_i      (rs_ID),
    .id_rt_i      (rt_ID),
    .id_uses_rt_i (uses_rt_ID),
    .hazard_o     (load_use)
  );
  // Same-cycle WB write lands in the operand so EX never sees a stale register file read
  assign rs_byp = RegWrite_WB && rd_WB != REG_W'(REG_ZERO) && rd_WB == rs_ID;
  assign rt_byp = RegWrite_WB && rd_WB != REG_W'(REG_ZERO) && rd_WB == rt_ID;
  assign cap = '{valid: 1'b1, rs: rs_ID, rt: rt_ID, dst: dst_ID,
                 rs_data: rs_byp ? wdata_WB : rs_data_ID,
                 rt_data: rt_byp ? wdata_WB : rt_data_ID,
                 imm: imm_ID,
                 ctrl: '{RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID},
                 alu_op: ALUOp_ID};
  assign ex_d = (flush_EX || (!hold_EX && (load_use || !valid_ID))) ? BUBBLE : hold_EX ? ex_q : cap;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ex_q <= '0;
    else ex_q <= ex_d;
  assign valid_EX    = ex_q.valid;
  assign rs_EX       = ex_q.rs;
  assign rt_EX       = ex_q.rt;
  assign dst_EX      = ex_q.dst;
  assign rs_data_EX  = ex_q.rs_data;
  assign rt_data_EX  = ex_q.rt_data;
  assign imm_EX      = ex_q.imm;
  assign RegWrite_EX = ex_q.ctrl.reg_write;
  assign MemRead_EX  = ex_q.ctrl.mem_read;
  assign MemWrite_EX = ex_q.ctrl.mem_write;
  assign MemtoReg_EX = ex_q.ctrl.mem_to_reg;
  assign ALUSrc_EX   = ex_q.ctrl.alu_src;
  assign ALUOp_EX    = ex_q.alu_op;
  assign stall_ID    = load_use | hold_EX;
`ifdef ID_EX_STALL_STATS_EN
  logic [31:0] lu_cnt_q, lu_cnt_d, fl_cnt_q, fl_cnt_d;
  assign lu_cnt_d = lu_cnt_q + 32'((load_use && !hold_EX && !flush_EX) && !(&lu_cnt_q));
  assign fl_cnt_d = fl_cnt_q + 32'(flush_EX && !(&fl_cnt_q));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  assign load_use_cnt = lu_cnt_q;
  assign flush_cnt    = fl_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: scoreboard bench for the ID/EX register, hazard stall, flush, hold and WB bypass.
module tb_id_ex_stage_reg;
  import id_ex_stage_reg_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        valid_ID, uses_rt_ID, RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID;
  logic [4:0]  rs_ID, rt_ID, dst_ID, rd_WB;
  logic [31:0] rs_data_ID, rt_data_ID, imm_ID, wdata_WB;
  logic [3:0]  ALUOp_ID;
  logic        RegWrite_WB, flush_EX, hold_EX;
  logic        valid_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, ALUSrc_EX, stall_ID;
  logic [4:0]  rs_EX, rt_EX, dst_EX;
  logic [31:0] rs_data_EX, rt_data_EX, imm_EX;
  logic [3:0]  ALUOp_EX;
`ifdef ID_EX_STALL_STATS_EN
  logic [31:0] load_use_cnt, flush_cnt;
`endif
  id_ex_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .valid_ID(valid_ID), .rs_ID(rs_ID), .rt_ID(rt_ID), .dst_ID(dst_ID),
    .uses_rt_ID(uses_rt_ID), .rs_data_ID(rs_data_ID), .rt_data_ID(rt_data_ID), .imm_ID(imm_ID),
    .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID),
    .MemtoReg_ID(MemtoReg_ID), .ALUSrc_ID(ALUSrc_ID), .ALUOp_ID(ALUOp_ID),
    .RegWrite_WB(RegWrite_WB), .rd_WB(rd_WB), .wdata_WB(wdata_WB), .flush_EX(flush_EX),
    .hold_EX(hold_EX), .valid_EX(valid_EX), .rs_EX(rs_EX), .rt_EX(rt_EX), .dst_EX(dst_EX),
    .rs_data_EX(rs_data_EX), .rt_data_EX(rt_data_EX), .imm_EX(imm_EX),
    .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
    .MemtoReg_EX(MemtoReg_EX), .ALUSrc_EX(ALUSrc_EX), .ALUOp_EX(ALUOp_EX), .stall_ID(stall_ID)
`ifdef ID_EX_STALL_STATS_EN
    , .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
`endif
  );
  typedef struct packed {
    logic        v;
    logic [4:0]  rs, rt, dst;
    logic [31:0] rsd, rtd, imm;
    logic        rw, mr, mw, m2r, as;
    logic [3:0]  op;
  } ex_t;
  localparam logic [4:0] C_LW = 5'b11011, C_RT = 5'b10000, C_SW = 5'b00101, C_ADDI = 5'b10001;
  ex_t m, sb[$];
  int passed = 0, total = 0, m_lu = 0, m_fl = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  function automatic ex_t dut_ex();
    return {valid_EX, rs_EX, rt_EX, dst_EX, rs_data_EX, rt_data_EX, imm_EX,
            RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, ALUSrc_EX, ALUOp_EX};
  endfunction
  task automatic id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                    input logic urt, input logic [4:0] c, input logic [3:0] op);
    valid_ID = 1'b1; rs_ID = rs; rt_ID = rt; dst_ID = dst; uses_rt_ID = urt;
    {RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID} = c;
    ALUOp_ID = op; rs_data_ID = $urandom; rt_data_ID = $urandom; imm_ID = $urandom;
  endtask
  task automatic cyc(input string tag);
    ex_t e;
    logic lu;
    #1;
    lu = m.v && m.mr && m.dst != 5'd0 && valid_ID && (m.dst == rs_ID || (uses_rt_ID && m.dst == rt_ID));
    chk({tag, ":stall"}, 128'(stall_ID), 128'(lu | hold_EX));
    e = '0;
    if (flush_EX) m_fl++;
    else if (hold_EX) e = m;
    else if (lu) m_lu++;
    else if (valid_ID) begin
      e.v = 1'b1; e.rs = rs_ID; e.rt = rt_ID; e.dst = dst_ID; e.imm = imm_ID;
      e.rsd = (RegWrite_WB && rd_WB != 5'd0 && rd_WB == rs_ID) ? wdata_WB : rs_data_ID;
      e.rtd = (RegWrite_WB && rd_WB != 5'd0 && rd_WB == rt_ID) ? wdata_WB : rt_data_ID;
      {e.rw, e.mr, e.mw, e.m2r, e.as} = {RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID};
      e.op = ALUOp_ID;
    end
    sb.push_back(e);
    m = e;
    @(posedge clk);
    #1;
    chk(tag, 128'(dut_ex()), 128'(sb.pop_front()));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    {valid_ID, uses_rt_ID, RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID} = '0;
    {rs_ID, rt_ID, dst_ID, rd_WB, rs_data_ID, rt_data_ID, imm_ID, wdata_WB, ALUOp_ID} = '0;
    {RegWrite_WB, flush_EX, hold_EX} = '0;
    m = '0;
    #12;
    chk("rst_ex", 128'(dut_ex()), 128'(0));
    chk("rst_stall", 128'(stall_ID), 128'(0));
    rst_n = 1'b1;
    cyc("idle");
    id(5'd1, 5'd5, 5'd5, 1'b0, C_LW, ALU_ADD); cyc("lw");
    id(5'd5, 5'd7, 5'd6, 1'b1, C_RT, ALU_ADD); cyc("add_bubble");
    chk("bubble_valid", 128'(valid_EX), 128'(0));
    chk("bubble_dst", 128'(dst_EX), 128'(0));
    cyc("add");
    chk("add_rs", 128'(rs_EX), 128'(5));
    id(5'd1, 5'd5, 5'd5, 1'b0, C_LW, ALU_ADD); cyc("lw2");
    id(5'd5, 5'd8, 5'd0, 1'b0, C_SW, ALU_ADD); cyc("sw_bubble");
    cyc("sw");
    id(5'd1, 5'd5, 5'd5, 1'b0, C_LW, ALU_ADD); cyc("lw3");
    id(5'd9, 5'd5, 5'd5, 1'b0, C_ADDI, ALU_ADD); cyc("addi_nostall");
    id(5'd3, 5'd4, 5'd2, 1'b1, C_RT, ALU_SUB); rs_data_ID = 32'h0;
    RegWrite_WB = 1'b1; rd_WB = 5'd3; wdata_WB = 32'hDEADBEEF; cyc("byp_rs");
    chk("byp_rs_data", 128'(rs_data_EX), 128'(32'hDEADBEEF));
    id(5'd3, 5'd4, 5'd2, 1'b1, C_RT, ALU_SUB); rs_data_ID = 32'h0; rd_WB = 5'd0; cyc("byp_rd0");
    chk("byp_rd0_data", 128'(rs_data_EX), 128'(0));
    id(5'd0, 5'd0, 5'd2, 1'b1, C_RT, ALU_OR); rs_data_ID = 32'h0; cyc("byp_zero");
    id(5'd1, 5'd4, 5'd2, 1'b1, C_RT, ALU_OR); rd_WB = 5'd4; cyc("byp_rt");
    chk("byp_rt_data", 128'(rt_data_EX), 128'(32'hDEADBEEF));
    RegWrite_WB = 1'b0;
    id(5'd2, 5'd3, 5'd4, 1'b1, C_RT, ALU_ADD); cyc("pre_hold");
    hold_EX = 1'b1;
    id(5'd7, 5'd7, 5'd7, 1'b1, C_RT, ALU_AND);
    for (int i = 0; i < 3; i++) cyc($sformatf("hold%0d", i));
    chk("hold_rs", 128'(rs_EX), 128'(2));
    flush_EX = 1'b1; cyc("hold_flush");
    flush_EX = 1'b0; hold_EX = 1'b0;
    id(5'd1, 5'd5, 5'd5, 1'b0, C_LW, ALU_ADD); cyc("lw4");
    id(5'd5, 5'd7, 5'd6, 1'b1, C_RT, ALU_ADD); flush_EX = 1'b1; cyc("lu_flush");
    flush_EX = 1'b0; cyc("after_flush");
    id(5'd1, 5'd5, 5'd5, 1'b0, C_LW, ALU_ADD); cyc("lw5");
    id(5'd5, 5'd7, 5'd6, 1'b1, C_RT, ALU_ADD);
    #1 chk("pre_rst_stall", 128'(stall_ID), 128'(1));
    rst_n = 1'b0;
    #1 chk("mid_rst_ex", 128'(dut_ex()), 128'(0));
    chk("mid_rst_stall", 128'(stall_ID), 128'(0));
    m = '0; m_lu = 0; m_fl = 0;
    #1 rst_n = 1'b1;
    cyc("post_rst");
    chk("post_rst_valid", 128'(valid_EX), 128'(1));
    for (int i = 0; i < 60; i++) begin
      id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
         1'($urandom), 5'($urandom), 4'($urandom));
      valid_ID = ($urandom_range(0, 3) != 0);
      hold_EX = ($urandom_range(0, 3) == 0);
      flush_EX = ($urandom_range(0, 7) == 0);
      RegWrite_WB = 1'($urandom); rd_WB = 5'($urandom_range(0, 3)); wdata_WB = $urandom;
      cyc($sformatf("rnd%0d", i));
    end
`ifdef ID_EX_STALL_STATS_EN
    chk("load_use_cnt", 128'(load_use_cnt), 128'(m_lu));
    chk("flush_cnt", 128'(flush_cnt), 128'(m_fl));
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
